// File: rtl/jtdsp16_pkg.sv
// Shared constants and helpers for the jtdsp16 serial port.
// FSM encodings, word width and frame lengths live here.
package jtdsp16_pkg;

    localparam int WORD_W  = 16;
    localparam int FLEN_16 = 16;
    localparam int FLEN_8  = 8;
    localparam int CNT_W   = 5;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_SHIFT = 1'b1;

    typedef enum logic {
        IDLE  = ST_IDLE,
        SHIFT = ST_SHIFT
    } state_t;

    // Shift one received bit into the input shifter in transmit order
    function automatic logic [WORD_W-1:0] rx_shift(
        input logic [WORD_W-1:0] cur,
        input logic              din,
        input logic              msb
    );
        return msb ? {cur[WORD_W-2:0], din} : {din, cur[WORD_W-1:1]};
    endfunction

    // Right-justify an 8-bit frame; its bits sit at the shift-in end
    function automatic logic [WORD_W-1:0] rx_frame(
        input logic [WORD_W-1:0] sh,
        input logic              len8,
        input logic              msb
    );
        if (!len8)
            return sh;
        return msb ? {8'h00, sh[7:0]} : {8'h00, sh[15:8]};
    endfunction

endpackage

// File: rtl/jtdsp16_sio_clkgen.sv
// Serial bit clock divider for the jtdsp16 serial port.
// ock toggles every DIV cen cycles; ticks mark the toggle cycles.
module jtdsp16_sio_clkgen #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic cen,
    output logic ock,
    output logic rise_tick,
    output logic fall_tick
);

    logic [7:0] cnt;
    logic       terminal;

    assign terminal  = cnt == 8'(DIV - 1);
    assign rise_tick = cen & terminal & ~ock;
    assign fall_tick = cen & terminal & ock;

    // Count cen cycles and flip ock at each half-period boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 8'd0;
            ock <= 1'b0;
        end else if (cen) begin
            if (terminal) begin
                cnt <= 8'd0;
                ock <= ~ock;
            end else begin
                cnt <= cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/jtdsp16_sio.sv
// jtdsp16 serial I/O: buffered transmitter and receiver
// sharing one internally generated bit clock.
module jtdsp16_sio
    import jtdsp16_pkg::*;
#(
    parameter int DIV = 4
) (
    input  logic              rst,
    input  logic              clk,
    input  logic              cen,
    input  logic              sdx_we,
    input  logic [WORD_W-1:0] sdx_din,
    input  logic              sdx_rd,
    output logic [WORD_W-1:0] sdx_dout,
    input  logic              olen,
    input  logic              msb_first,
    input  logic              sdi,
    output logic              ock,
    output logic              old,
    output logic              sdo,
    output logic              obe,
    output logic              ose,
    output logic              ibf
);

    logic              rise_tick;
    logic              fall_tick;
    state_t            state;
    logic [WORD_W-1:0] obuf;
    logic [WORD_W-1:0] oshift;
    logic [WORD_W-1:0] ishift;
    logic [WORD_W-1:0] ibuf;
    logic [CNT_W-1:0]  bitcnt;
    logic              olen_l;
    logic              msb_l;
    logic              last;
    logic              load;
    logic              sample;
    logic [WORD_W-1:0] ld_shift;
    logic              ld_sdo;
    logic [CNT_W-1:0]  ld_cnt;
    logic [WORD_W-1:0] rx_next;

    jtdsp16_sio_clkgen #(
        .DIV       (DIV)
    ) u_clkgen (
        .clk       (clk),
        .rst       (rst),
        .cen       (cen),
        .ock       (ock),
        .rise_tick (rise_tick),
        .fall_tick (fall_tick)
    );

    assign last   = bitcnt == CNT_W'(1);
    assign load   = fall_tick & ~obe & ((state == IDLE) | last);
    assign sample = rise_tick & (state == SHIFT);

    // 8-bit MSB-first frames are pre-aligned so bit 15 is always next
    assign ld_shift = (msb_first & olen) ? {obuf[7:0], 8'h00} : obuf;
    assign ld_sdo   = msb_first ? ld_shift[WORD_W-1] : ld_shift[0];
    assign ld_cnt   = olen ? CNT_W'(FLEN_8) : CNT_W'(FLEN_16);
    assign rx_next  = rx_shift(ishift, sdi, msb_l);

    assign sdx_dout = ibuf;

    // Output buffer: a core write always wins over the load that empties it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            obuf <= '0;
            obe  <= 1'b1;
        end else if (cen && sdx_we) begin
            obuf <= sdx_din;
            obe  <= 1'b0;
        end else if (load) begin
            obe  <= 1'b1;
        end
    end

    // Transmit FSM: load or advance one bit on each falling bit-clock edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            oshift <= '0;
            bitcnt <= '0;
            olen_l <= 1'b0;
            msb_l  <= 1'b0;
            old    <= 1'b0;
            ose    <= 1'b1;
            sdo    <= 1'b0;
        end else if (fall_tick) begin
            if (load) begin
                state  <= SHIFT;
                oshift <= ld_shift;
                bitcnt <= ld_cnt;
                olen_l <= olen;
                msb_l  <= msb_first;
                old    <= 1'b1;
                ose    <= 1'b0;
                sdo    <= ld_sdo;
            end else if (state == SHIFT) begin
                old <= 1'b0;
                if (last) begin
                    state <= IDLE;
                    ose   <= 1'b1;
                    sdo   <= 1'b0;
                end else begin
                    bitcnt <= bitcnt - CNT_W'(1);
                    if (msb_l) begin
                        oshift <= {oshift[WORD_W-2:0], 1'b0};
                        sdo    <= oshift[WORD_W-2];
                    end else begin
                        oshift <= {1'b0, oshift[WORD_W-1:1]};
                        sdo    <= oshift[1];
                    end
                end
            end
        end
    end

    // Receive shifter: sample mid-bit, publish the word after the last bit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ishift <= '0;
            ibuf   <= '0;
        end else if (sample) begin
            ishift <= rx_next;
            if (last)
                ibuf <= rx_frame(rx_next, olen_l, msb_l);
        end
    end

    // Input-buffer-full flag: a new word beats a simultaneous read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            ibf <= 1'b0;
        else if (sample && last)
            ibf <= 1'b1;
        else if (cen && sdx_rd)
            ibf <= 1'b0;
    end

endmodule

// File: tb/tb_jtdsp16_sio.sv
// Self-checking bench for jtdsp16_sio with sdo looped back to sdi.
// Bit streams are predicted from word, length and bit order.
module tb_jtdsp16_sio;

    localparam int DIV = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cen = 1'b1;
    logic        sdx_we = 1'b0;
    logic [15:0] sdx_din = 16'h0;
    logic        sdx_rd = 1'b0;
    logic [15:0] sdx_dout;
    logic        olen = 1'b0;
    logic        msb_first = 1'b1;
    logic        sdi;
    logic        ock, old, sdo, obe, ose, ibf;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic sdo;
        logic old;
        logic obe;
        logic ose;
    } ent_t;

    ent_t q[$];
    logic exp_bits[$];
    logic exp_old[$];
    logic last_ock = 1'b0;

    assign sdi = sdo;

    jtdsp16_sio #(
        .DIV       (DIV)
    ) dut (
        .rst       (rst),
        .clk       (clk),
        .cen       (cen),
        .sdx_we    (sdx_we),
        .sdx_din   (sdx_din),
        .sdx_rd    (sdx_rd),
        .sdx_dout  (sdx_dout),
        .olen      (olen),
        .msb_first (msb_first),
        .sdi       (sdi),
        .ock       (ock),
        .old       (old),
        .sdo       (sdo),
        .obe       (obe),
        .ose       (ose),
        .ibf       (ibf)
    );

    always #5 clk = ~clk;

    // Record the line state at the start of every bit period
    always @(negedge clk) begin
        if (last_ock === 1'b1 && ock === 1'b0)
            q.push_back({sdo, old, obe, ose});
        last_ock = ock;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic get_entry(output ent_t e);
        int n;
        n = 0;
        e = '0;
        while (q.size() == 0 && n < 300) begin
            tick();
            n++;
        end
        if (q.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL timeout obs=none exp=bit_event");
        end else begin
            e = q.pop_front();
        end
    endtask

    task automatic skip_idle(output ent_t e);
        int n;
        n = 0;
        get_entry(e);
        while (e.ose === 1'b1 && n < 60) begin
            get_entry(e);
            n++;
        end
    endtask

    function automatic void add_frame(input logic [15:0] w,
                                      input logic ol, input logic mf);
        int n;
        n = ol ? 8 : 16;
        for (int i = 0; i < n; i++) begin
            exp_bits.push_back(w[mf ? n - 1 - i : i]);
            exp_old.push_back(i == 0);
        end
    endfunction

    task automatic write_word(input logic [15:0] w, input logic ol,
                              input logic mf);
        olen = ol;
        msb_first = mf;
        sdx_din = w;
        sdx_we = 1'b1;
        tick();
        sdx_we = 1'b0;
    endtask

    task automatic do_freeze();
        logic [22:0] snap;
        cen = 1'b0;
        snap = {ock, old, sdo, obe, ose, ibf, sdx_dout};
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("freeze%0d", k),
                {9'h0, ock, old, sdo, obe, ose, ibf, sdx_dout}, {9'h0, snap});
        end
        cen = 1'b1;
    endtask

    task automatic check_stream(input string tag, input ent_t first,
                                input int freeze_at);
        ent_t e;
        int n;
        e = first;
        n = exp_bits.size();
        for (int i = 0; i < n; i++) begin
            if (i > 0)
                get_entry(e);
            chk($sformatf("%s_sdo%0d", tag, i), e.sdo, exp_bits[i]);
            chk($sformatf("%s_old%0d", tag, i), e.old, exp_old[i]);
            if (i == freeze_at)
                do_freeze();
        end
        exp_bits.delete();
        exp_old.delete();
    endtask

    task automatic finish_frame(input string tag, input logic [15:0] dout);
        ent_t e;
        get_entry(e);
        chk({tag, "_idle_ose"}, e.ose, 1'b1);
        chk({tag, "_idle_sdo"}, e.sdo, 1'b0);
        chk({tag, "_ibf"}, ibf, 1'b1);
        chk({tag, "_dout"}, sdx_dout, dout);
        sdx_rd = 1'b1;
        tick();
        sdx_rd = 1'b0;
        chk({tag, "_ibf_rd"}, ibf, 1'b0);
    endtask

    task automatic single(input string tag, input logic [15:0] w,
                          input logic ol, input logic mf, input int fz);
        ent_t e;
        write_word(w, ol, mf);
        add_frame(w, ol, mf);
        skip_idle(e);
        chk({tag, "_obe_load"}, e.obe, 1'b1);
        check_stream(tag, e, fz);
        finish_frame(tag, ol ? {8'h00, w[7:0]} : w);
    endtask

    initial begin
        ent_t e;
        logic [15:0] w;
        logic ol, mf;

        tick();
        chk("rst_ock", ock, 1'b0);
        chk("rst_old", old, 1'b0);
        chk("rst_sdo", sdo, 1'b0);
        chk("rst_obe", obe, 1'b1);
        chk("rst_ose", ose, 1'b1);
        chk("rst_ibf", ibf, 1'b0);
        chk("rst_dout", sdx_dout, 16'h0);
        rst = 1'b1;
        q.delete();

        single("a5c3", 16'hA5C3, 1'b0, 1'b1, -1);
        single("12f0", 16'h12F0, 1'b1, 1'b0, -1);

        write_word(16'h0001, 1'b0, 1'b1);
        add_frame(16'h0001, 1'b0, 1'b1);
        add_frame(16'hFFFF, 1'b0, 1'b1);
        skip_idle(e);
        write_word(16'hFFFF, 1'b0, 1'b1);
        check_stream("chain", e, -1);
        finish_frame("chain", 16'hFFFF);

        single("freeze", 16'hA5C3, 1'b0, 1'b1, 6);

        for (int r = 0; r < 6; r++) begin
            w = 16'($urandom);
            ol = 1'($urandom_range(0, 1));
            mf = 1'($urandom_range(0, 1));
            single($sformatf("rnd%0d", r), w, ol, mf, -1);
        end

        write_word(16'hA5C3, 1'b0, 1'b1);
        skip_idle(e);
        for (int i = 1; i <= 7; i++)
            get_entry(e);
        rst = 1'b0;
        #1;
        chk("mid_rst_ock", ock, 1'b0);
        chk("mid_rst_old", old, 1'b0);
        chk("mid_rst_sdo", sdo, 1'b0);
        chk("mid_rst_obe", obe, 1'b1);
        chk("mid_rst_ose", ose, 1'b1);
        chk("mid_rst_ibf", ibf, 1'b0);
        chk("mid_rst_dout", sdx_dout, 16'h0);
        repeat (3) tick();
        rst = 1'b1;
        q.delete();
        for (int k = 0; k < 40; k++) begin
            tick();
            chk($sformatf("post_rst_sdo%0d", k), sdo, 1'b0);
            chk($sformatf("post_rst_obe%0d", k), obe, 1'b1);
        end
        q.delete();

        single("recover", 16'h3C5A, 1'b0, 1'b0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
